mem_latency_ram: RTL

MEM_LATENCY_RAM -- requirements
Module: mem_latency_ram

---
 rtl/mem_latency_ram.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_latency_ram.sv
// Word-addressed RAM model with a fixed BUSY latency per access, fed by a held
// request/level handshake from the coherence controller.
//   state  | meaning
//   S_IDLE | FREE, no access in progress
//   S_WAIT | BUSY, counting latency for the latched request
//   S_ACC  | ACCESS, ramload valid for exactly this cycle
//   S_ERR  | ERROR, ramload = 32'hBAD1BAD1
module mem_latency_ram #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0]  LAT_C   = 4'(LAT);
  localparam logic [31:0] ERR_VAL = 32'hBAD1BAD1;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     ramload_q, ramload_d;
  logic [31:0]     mem_q [2**AW];

  logic            req, bad, differs, do_acc;
  logic [AW-1:0]   word_idx;

  assign word_idx = memaddr[AW+1:2];
  assign req      = memREN | memWEN;
  assign bad      = (memREN & memWEN) | (memaddr[1:0] != 2'b00) |
                    ((memaddr >> (AW + 2)) != 32'd0);
  // Only memstore matters for a write; a read ignores the data bus.
  assign differs  = (word_idx != addr_q) | (memWEN != wen_q) |
                    (memWEN & (memstore != data_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    data_d    = data_q;
    ramload_d = ramload_q;
    do_acc    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (bad) begin
          state_d   = S_ERR;
          ramload_d = ERR_VAL;
        end else if (differs) begin
          addr_d = word_idx;
          wen_d  = memWEN;
          data_d = memstore;
          cnt_d  = 4'd1;
        end else if (cnt_q < LAT_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d   = S_ACC;
          do_acc    = 1'b1;
          ramload_d = wen_q ? data_q : mem_q[addr_q];
        end
      end
      // IDLE, ACC and ERR all treat the sampled request as a fresh one.
      default: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (bad) begin
          state_d   = S_ERR;
          ramload_d = ERR_VAL;
        end else begin
          state_d = S_WAIT;
          addr_d  = word_idx;
          wen_d   = memWEN;
          data_d  = memstore;
          cnt_d   = 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      data_q    <= 32'd0;
      ramload_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      data_q    <= data_d;
      ramload_q <= ramload_d;
    end
  end

  // Array is not reset; a reset on the access edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (do_acc && wen_q && !RST) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign ramload  = ramload_q;
  assign ramstate = state_q;

endmodule
